// File: rtl/commit_cu.sv
// rtl/commit_cu.sv - commit control unit: retire strobes, multi-cycle commit sequencing, flush/redirect
//
// Sequences retirement of the ROB head according to its commit class:
// single-cycle retires (RF write, store commit, branches), CSR handshake,
// FENCE store-buffer drain, WFI sleep, and a one-cycle flush/redirect.
//
// Optional feature macro: LEN5_COMMIT_INSTRET_EN (adds instret_o counter).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i, comm_type_i  ROB head valid and commit class (encoding below)
//   mispredicted_i        head jump/branch was mispredicted
//   sb_store_ready_i      store buffer accepts a store commit
//   sb_empty_i            store buffer fully drained
//   csr_ready_i           CSR unit completed the access
//   irq_i                 interrupt pending (WFI wake-up only)
//   ready_o               pop ROB head
//   int_rf_we_o           integer RF write
//   sb_store_commit_o     store commit strobe
//   csr_valid_o           CSR execute request
//   flush_o, fe_redirect_o, redirect_sel_o   flush and front-end redirect
//   instret_o             retired-instruction count (macro only)
//
// comm_type_i encoding: 0 NONE, 1 INT_RF, 2 LOAD, 3 STORE, 4 JUMP, 5 BRANCH,
// 6 CSR, 7 FENCE, 8 WFI, 9 ECALL, 10 EBREAK, 11 EXCEPT, 12 MRET; others act as NONE.

module commit_cu #(
    parameter int INSTRET_W = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [3:0] comm_type_i,
    input  logic       mispredicted_i,
    input  logic       sb_store_ready_i,
    input  logic       sb_empty_i,
    input  logic       csr_ready_i,
    input  logic       irq_i,
    output logic       ready_o,
    output logic       int_rf_we_o,
    output logic       sb_store_commit_o,
    output logic       csr_valid_o,
    output logic       flush_o,
    output logic       fe_redirect_o,
    output logic [1:0] redirect_sel_o
`ifdef LEN5_COMMIT_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] instret_o
`endif
);

    localparam logic [3:0] CT_INT_RF = 4'd1;
    localparam logic [3:0] CT_LOAD   = 4'd2;
    localparam logic [3:0] CT_STORE  = 4'd3;
    localparam logic [3:0] CT_JUMP   = 4'd4;
    localparam logic [3:0] CT_BRANCH = 4'd5;
    localparam logic [3:0] CT_CSR    = 4'd6;
    localparam logic [3:0] CT_FENCE  = 4'd7;
    localparam logic [3:0] CT_WFI    = 4'd8;
    localparam logic [3:0] CT_ECALL  = 4'd9;
    localparam logic [3:0] CT_EBREAK = 4'd10;
    localparam logic [3:0] CT_EXCEPT = 4'd11;
    localparam logic [3:0] CT_MRET   = 4'd12;

    localparam logic [1:0] SEL_MISPRED = 2'd0;
    localparam logic [1:0] SEL_TRAP    = 2'd1;
    localparam logic [1:0] SEL_MRET    = 2'd2;
    localparam logic [1:0] SEL_NEXT    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CSR,
        S_WAIT_FENCE,
        S_WAIT_WFI,
        S_FLUSH
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sel_q   <= SEL_MISPRED;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign redirect_sel_o = sel_q;

    // Strobes are suppressed while reset is asserted so that nothing is
    // popped or flushed in the reset cycle itself.
    always_comb begin
        state_d           = state_q;
        sel_d             = sel_q;
        ready_o           = 1'b0;
        int_rf_we_o       = 1'b0;
        sb_store_commit_o = 1'b0;
        csr_valid_o       = 1'b0;
        flush_o           = 1'b0;
        fe_redirect_o     = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        case (comm_type_i)
                            CT_INT_RF, CT_LOAD: begin
                                ready_o     = 1'b1;
                                int_rf_we_o = 1'b1;
                            end
                            CT_STORE: begin
                                ready_o           = sb_store_ready_i;
                                sb_store_commit_o = sb_store_ready_i;
                            end
                            CT_JUMP, CT_BRANCH: begin
                                ready_o     = 1'b1;
                                int_rf_we_o = (comm_type_i == CT_JUMP);
                                if (mispredicted_i) begin
                                    state_d = S_FLUSH;
                                    sel_d   = SEL_MISPRED;
                                end
                            end
                            CT_CSR: begin
                                csr_valid_o = 1'b1;
                                state_d     = S_WAIT_CSR;
                            end
                            CT_FENCE: state_d = S_WAIT_FENCE;
                            CT_WFI: begin
                                ready_o = 1'b1;
                                state_d = S_WAIT_WFI;
                            end
                            CT_ECALL, CT_EBREAK, CT_EXCEPT: begin
                                ready_o = 1'b1;
                                state_d = S_FLUSH;
                                sel_d   = SEL_TRAP;
                            end
                            CT_MRET: begin
                                ready_o = 1'b1;
                                state_d = S_FLUSH;
                                sel_d   = SEL_MRET;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WAIT_CSR: begin
                    csr_valid_o = 1'b1;
                    if (valid_i && csr_ready_i) begin
                        ready_o     = 1'b1;
                        int_rf_we_o = 1'b1;
                        state_d     = S_FLUSH;
                        sel_d       = SEL_NEXT;
                    end
                end
                S_WAIT_FENCE: begin
                    if (valid_i && sb_empty_i) begin
                        ready_o = 1'b1;
                        state_d = S_FLUSH;
                        sel_d   = SEL_NEXT;
                    end
                end
                S_WAIT_WFI: begin
                    if (irq_i) begin
                        state_d = S_FLUSH;
                        sel_d   = SEL_TRAP;
                    end
                end
                S_FLUSH: begin
                    flush_o       = 1'b1;
                    fe_redirect_o = 1'b1;
                    state_d       = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef LEN5_COMMIT_INSTRET_EN
    // Trapping instructions are popped but do not count as retired.
    logic counts;
    assign counts = ready_o && (comm_type_i != CT_ECALL) && (comm_type_i != CT_EBREAK)
                    && (comm_type_i != CT_EXCEPT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_o <= '0;
        end else if (counts) begin
            instret_o <= instret_o + 1'b1;
        end
    end
`else
    localparam int unused_instret_w = INSTRET_W;
`endif

endmodule

// File: tb/tb_commit_cu.sv
// tb/tb_commit_cu.sv - randomized + directed self-checking bench for commit_cu

module tb_commit_cu;

    localparam int IW = 4;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [3:0] ctype;
    logic       mispred;
    logic       sb_ready;
    logic       sb_empty;
    logic       csr_ready;
    logic       irq;
    logic       ready;
    logic       we;
    logic       st_commit;
    logic       csr_valid;
    logic       flush;
    logic       redirect;
    logic [1:0] sel;
`ifdef LEN5_COMMIT_INSTRET_EN
    logic [IW-1:0] instret;
`endif

    commit_cu #(.INSTRET_W(IW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .valid_i          (valid),
        .comm_type_i      (ctype),
        .mispredicted_i   (mispred),
        .sb_store_ready_i (sb_ready),
        .sb_empty_i       (sb_empty),
        .csr_ready_i      (csr_ready),
        .irq_i            (irq),
        .ready_o          (ready),
        .int_rf_we_o      (we),
        .sb_store_commit_o(st_commit),
        .csr_valid_o      (csr_valid),
        .flush_o          (flush),
        .fe_redirect_o    (redirect),
        .redirect_sel_o   (sel)
`ifdef LEN5_COMMIT_INSTRET_EN
        ,
        .instret_o        (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] NONE = 0, INT_RF = 1, LOAD = 2, STORE = 3, JUMP = 4, BRANCH = 5,
                           CSR = 6, FENCE = 7, WFI = 8, ECALL = 9, EBREAK = 10, EXCEPT = 11,
                           MRET = 12;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: what the head is blocked on (0 nothing, 1 CSR, 2 FENCE, 3 WFI),
    // whether a redirect is owed on the next cycle, its cause and the count.
    int m_block   = 0;
    bit m_flush   = 0;
    int m_sel     = 0;
    int m_instret = 0;

    bit e_ready, e_we, e_st, e_csr, e_flush;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic v, input logic [3:0] t, input logic mp,
                          input logic sbr, input logic sbe, input logic cr, input logic ir);
        rst = r; valid = v; ctype = t; mispred = mp;
        sb_ready = sbr; sb_empty = sbe; csr_ready = cr; irq = ir;
        #4;
    endtask

    // Expected strobes derived from the retirement rules, then checked.
    task automatic check_model();
        e_ready = 0; e_we = 0; e_st = 0; e_csr = 0; e_flush = 0;
        if (!rst) begin
            if (m_flush) e_flush = 1;
            else if (m_block == 1) begin
                e_csr = 1;
                e_ready = valid && csr_ready;
                e_we = e_ready;
            end else if (m_block == 2) e_ready = valid && sb_empty;
            else if (m_block == 0 && valid) begin
                e_ready = ctype inside {INT_RF, LOAD, JUMP, BRANCH, WFI, ECALL, EBREAK, EXCEPT, MRET}
                          || (ctype == STORE && sb_ready);
                e_we    = ctype inside {INT_RF, LOAD, JUMP};
                e_st    = (ctype == STORE && sb_ready);
                e_csr   = (ctype == CSR);
            end
        end
        cmp("ready", ready, e_ready);
        cmp("int_rf_we", we, e_we);
        cmp("store_commit", st_commit, e_st);
        cmp("csr_valid", csr_valid, e_csr);
        cmp("flush", flush, e_flush);
        cmp("fe_redirect", redirect, e_flush);
        if (e_flush) cmp("redirect_sel", sel, m_sel);
`ifdef LEN5_COMMIT_INSTRET_EN
        cmp("instret", instret, m_instret);
`endif
    endtask

    task automatic owe_flush(input int s);
        m_flush = 1; m_sel = s; m_block = 0;
    endtask

    task automatic tick();
        bit counted;
        counted = e_ready && !(ctype inside {ECALL, EBREAK, EXCEPT});
        @(posedge clk);
        if (rst) begin
            m_block = 0; m_flush = 0; m_sel = 0; m_instret = 0;
        end else begin
            if (counted) m_instret = (m_instret + 1) % (1 << IW);
            if (m_flush) m_flush = 0;
            else if (m_block == 1) begin
                if (valid && csr_ready) owe_flush(3);
            end else if (m_block == 2) begin
                if (valid && sb_empty) owe_flush(3);
            end else if (m_block == 3) begin
                if (irq) owe_flush(1);
            end else if (valid) begin
                if (ctype inside {JUMP, BRANCH} && mispred) owe_flush(0);
                else if (ctype == CSR) m_block = 1;
                else if (ctype == FENCE) m_block = 2;
                else if (ctype == WFI) m_block = 3;
                else if (ctype inside {ECALL, EBREAK, EXCEPT}) owe_flush(1);
                else if (ctype == MRET) owe_flush(2);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_in(1, 0, NONE, 0, 0, 0, 0, 0);
        check_model(); tick();
        set_in(1, 0, NONE, 0, 0, 0, 0, 0);
        check_model(); tick();
    endtask

    initial begin
        set_in(1, 0, NONE, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_reset();

        // Post-reset state
        set_in(0, 0, NONE, 0, 0, 0, 0, 0);
        check_model();
        cmp("rst_ready", ready, 0); cmp("rst_flush", flush, 0); cmp("rst_sel", sel, 0);
        tick();

        // Four back-to-back INT_RF retirements
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, INT_RF, 0, 0, 0, 0, 0);
            check_model(); cmp("intrf_ready", ready, 1); cmp("intrf_we", we, 1);
            tick();
        end
`ifdef LEN5_COMMIT_INSTRET_EN
        set_in(0, 0, NONE, 0, 0, 0, 0, 0);
        cmp("instret_4", instret, 4);
`endif

        // Store stalled three cycles
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, STORE, 0, i == 3, 0, 0, 0);
            check_model();
            cmp("store_ready", ready, i == 3); cmp("store_commit_lit", st_commit, i == 3);
            tick();
        end

        // Mispredicted branch
        set_in(0, 1, BRANCH, 1, 0, 0, 0, 0);
        check_model(); cmp("br_ready", ready, 1); tick();
        set_in(0, 0, NONE, 0, 0, 0, 0, 0);
        check_model(); cmp("br_flush", flush, 1); cmp("br_redir", redirect, 1);
        cmp("br_sel", sel, 0); tick();
        set_in(0, 1, INT_RF, 0, 0, 0, 0, 0);
        check_model(); cmp("br_idle", ready, 1); cmp("br_noflush", flush, 0); tick();

        // CSR completing on the third cycle
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, CSR, 0, 0, 0, i == 2, 0);
            check_model(); cmp("csr_valid_lit", csr_valid, 1);
            cmp("csr_ready_lit", ready, i == 2); cmp("csr_we_lit", we, i == 2);
            tick();
        end
        set_in(0, 0, NONE, 0, 0, 0, 0, 0);
        check_model(); cmp("csr_flush", flush, 1); cmp("csr_sel", sel, 3); tick();

        // FENCE drain: five cycles without pop, then pop and flush
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1, FENCE, 0, 0, i == 5, 0, 0);
            check_model(); cmp("fence_ready", ready, i == 5);
            tick();
        end
        set_in(0, 0, NONE, 0, 0, 0, 0, 0);
        check_model(); cmp("fence_flush", flush, 1); cmp("fence_sel", sel, 3); tick();

        // WFI woken after four cycles
        set_in(0, 1, WFI, 0, 0, 0, 0, 0);
        check_model(); cmp("wfi_ready", ready, 1); tick();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, NONE, 0, 0, 0, 0, i == 4);
            check_model(); cmp("wfi_sleep", flush, 0); tick();
        end
        set_in(0, 0, NONE, 0, 0, 0, 0, 0);
        check_model(); cmp("wfi_flush", flush, 1); cmp("wfi_sel", sel, 1); tick();

        // EXCEPT then reset during the flush cycle
        set_in(0, 1, EXCEPT, 0, 0, 0, 0, 0);
        check_model(); cmp("exc_ready", ready, 1); tick();
        set_in(1, 0, NONE, 0, 0, 0, 0, 0);
        check_model(); tick();
        set_in(0, 0, NONE, 0, 0, 0, 0, 0);
        check_model(); cmp("exc_dropped", flush, 0);
`ifdef LEN5_COMMIT_INSTRET_EN
        cmp("exc_instret0", instret, 0);
`endif
        tick();
        set_in(0, 1, INT_RF, 0, 0, 0, 0, 0);
        check_model(); cmp("post_rst_idle", ready, 1); tick();

        // Sixteen retirements from zero wrap a 4-bit counter
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(0, 1, LOAD, 0, 0, 0, 0, 0);
            check_model(); tick();
        end
`ifdef LEN5_COMMIT_INSTRET_EN
        set_in(0, 0, NONE, 0, 0, 0, 0, 0);
        cmp("instret_wrap", instret, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(99) == 0, $urandom_range(9) < 8, 4'($urandom_range(15)),
                   1'($urandom), 1'($urandom), $urandom_range(3) == 0, $urandom_range(2) == 0,
                   $urandom_range(4) == 0);
            check_model();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
